// File: rtl/tdm_demux4.sv
// tdm_demux4 - sequential 1-to-4 time-division demultiplexer.
//
// Collects one lane-wide sample per enabled clock in slot order 0..3 and
// publishes the rebuilt 4-lane word with a one-cycle valid strobe. The slot
// counter is fed back upstream as the 4:1 mux select.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   en       - sample qualifier; din/sync consumed only when high
//   sync     - marks din as slot 0 of a new frame
//   din      - serial lane sample (W bits)
//   sel      - slot expected this cycle (upstream mux select)
//   y        - reconstructed word, lane k at y[k*W +: W]
//   valid    - one-cycle pulse when y updates
//   sync_err - sticky flag, sync seen mid-frame
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for the first sync, slot held at 0
// RUN   | capturing frames; slot counts 0..3 and wraps

module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           sync,
  input  logic [W-1:0]   din,
  output logic [1:0]     sel,
  output logic [4*W-1:0] y,
  output logic           valid,
  output logic           sync_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [1:0]       slot, slot_nxt;
  // lanes 0..2 of the frame in progress; lane 3 comes straight from din
  logic [3*W-1:0]   shadow, shadow_nxt;
  logic [4*W-1:0]   y_nxt;
  logic             valid_nxt;
  logic             err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      slot     <= 2'd0;
      shadow   <= '0;
      y        <= '0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      slot     <= slot_nxt;
      shadow   <= shadow_nxt;
      y        <= y_nxt;
      valid    <= valid_nxt;
      sync_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    shadow_nxt = shadow;
    y_nxt      = y;
    valid_nxt  = 1'b0;
    err_nxt    = sync_err;

    if (en) begin
      case (state)
        IDLE: begin
          if (sync) begin
            shadow_nxt[0 +: W] = din;
            slot_nxt           = 2'd1;
            state_nxt          = RUN;
          end
        end
        RUN: begin
          if (sync && (slot != 2'd0)) begin
            // resync: drop the partial frame, this sample is the new slot 0
            shadow_nxt[0 +: W] = din;
            slot_nxt           = 2'd1;
            err_nxt            = 1'b1;
          end else begin
            case (slot)
              2'd0: shadow_nxt[0 +: W] = din;
              2'd1: shadow_nxt[W +: W] = din;
              2'd2: shadow_nxt[2*W +: W] = din;
              default: begin
                y_nxt     = {din, shadow};
                valid_nxt = 1'b1;
              end
            endcase
            slot_nxt = slot + 2'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign sel = slot;

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Sequential 1-to-4 time-division demultiplexer. Receives one lane-wide sample per enabled clock, in slot order 0..3, and rebuilds a registered 4-lane word. It also drives the slot index (`sel`) back to the upstream 4:1 mux select, which closes the serialize/deserialize loop. It sits directly behind the team's 4:1 mux and presents a parallel word with a one-cycle `valid` strobe to downstream logic.

## Interface
Parameters:
- `W`, default 1: data width of one lane.

Ports:
- `clk` — input, 1 — single clock; all state changes on the rising edge.
- `rst` — input, 1 — reset, asynchronous, active-high.
- `en` — input, 1 — sample qualifier; `din`/`sync` are consumed only on edges with `en=1`.
- `sync` — input, 1 — marks the current `din` as slot 0 of a new frame; ignored when `en=0`.
- `din` — input, W — serial lane sample.
- `sel` — output, 2 — slot expected on this cycle; drives upstream mux select `s`.
- `y` — output, 4*W — reconstructed word; lane k at `y[k*W +: W]`.
- `valid` — output, 1 — one-cycle pulse when `y` is updated.
- `sync_err` — output, 1 — sticky; set on a sync arriving mid-frame.

## Operation
- Reset (asynchronous, `rst=1`) forces:
  - state = IDLE, slot counter = 0, shadow register = 0;
  - `sel=0`, `y=0`, `valid=0`, `sync_err=0`.
- States:
  - **IDLE**: waiting for the first sync.
    - `en=1 & sync=1`: shadow lane 0 <= `din`, slot <= 1, go to RUN.
    - `en=1 & sync=0`: sample ignored, stay in IDLE.
  - **RUN**: capturing a frame.
    - `en=1`, `sync=0`, slot 0..2: shadow[slot] <= `din`, slot <= slot+1.
    - `en=1`, `sync=0`, slot=3: `y` <= {`din`, shadow[2:0]}, `valid` <= 1, slot wraps to 0, stay in RUN (continuous frames; a sync is not required each frame).
    - `en=1`, `sync=1`, slot=0: normal frame start, same as the `sync=0` case.
    - `en=1`, `sync=1`, slot≠0: resync.
      - Partial frame is discarded (`y` is not updated, no `valid`).
      - Shadow lane 0 <= `din`, slot <= 1.
      - `sync_err` <= 1.
  - `en=0` in any state: slot, shadow, `y` and `sync_err` hold; `valid` <= 0.
- Shadow lanes not yet written in a frame keep their stale value. This does not matter, because `y` updates only on a full 4-sample frame.
- `sync_err` clears only on `rst`.
- Slot counter is 2 bits; the wrap from 3 to 0 is natural modulo-4.
- `sel` equals the slot counter. In IDLE, `sel=0`.

## Timing
- `sel` is a registered value. The upstream mux sees the new select on the cycle after each enabled edge. `din` must be the mux output for the current `sel`.
- `y` and `valid` are both registered and change on the same edge: the one that samples slot 3.
  - `valid` is high for exactly one cycle after that edge.
  - It deasserts on the next edge regardless of `en`.
- Minimum frame time is 4 enabled cycles. With `en` held high, back-to-back frames give `valid` every 4th cycle.
- Latency: slot-0 sample to `y` visible = 4 enabled edges.
- Reset asserted mid-frame: all outputs go to zero immediately, without waiting for a clock.
- After reset deasserts, the block stays in IDLE until `en=1 & sync=1`.

## Test plan
All scenarios use W=1.
1. **Reset values.** Hold `rst=1` for 2 cycles with random `din`/`en`/`sync`. Required: `y=4'b0000`, `valid=0`, `sel=0`, `sync_err=0`.
2. **Basic frame.** Enabled samples `din`=0,1,0,1 with `sync=1` on the first. Required:
   - `sel` steps 0,1,2,3.
   - `y=4'b1010` after the 4th edge.
   - `valid` high for exactly one cycle; `sync_err=0`.
3. **Continuous frames, no further sync.** Follow scenario 2 directly with `din`=1,1,0,0. Required: `y=4'b0011`, second `valid` pulse exactly 4 cycles after the first.
4. **Enable gaps.**
   - Frame `din`=1,0,0,0 with `en=0` for 3 cycles after slot 1.
   - Required during the gap: `sel` holds at 2, no `valid`.
   - Required at end: `y=4'b0001` after the 4th enabled sample.
5. **Mid-frame resync.** Sync at slot 2, then a full frame `din`=0,0,1,1. Required:
   - `sync_err=1` from the resync edge onward.
   - `y` unchanged until the new frame completes, then `y=4'b1100`.
   - `sync_err` still 1 after that; cleared only by `rst`.
6. **Async reset mid-frame, then ignored samples.**
   - Pulse `rst` between clock edges at slot 2. Required: outputs zero before the next edge.
   - Then apply `en=1`, `sync=0` for 5 cycles. Required: `sel=0`, no `valid`, `y=0`.
   - Loopback check: drive the 4:1 mux select from `sel` with mux inputs `4'b0110`. Required: `y=4'b0110`.
